amp_pwr_ctrl: RTL and testbench

Power/fault sequencer for the class-D amplifier stage. Owns `sht_dwn` and gates speaker drive: it holds the amp in shutdown after reset, releases it, and unmutes on a sample boundary. On an amp fault it shuts down and retries, and it locks out after repeated faults. It sits beside `spkr_drv` in the top level; `aud_en` gates the PDM drivers, and `vld` is the I2S sample strobe.

---
 rtl/amp_pwr_if.sv | 21 ++
 rtl/amp_pwr_ctrl.sv | 117 +++++++++++
 tb/tb_amp_pwr_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_pwr_if.sv
// Control and status bundle between the class-D amplifier power sequencer and
// the surrounding I2S / fault / host logic.
interface amp_pwr_if;
    logic       Flt_n;
    logic       vld;
    logic       clr_lockout;
    logic       sht_dwn;
    logic       aud_en;
    logic       lockout;
    logic [1:0] retry_cnt;

    modport master (
        output Flt_n, vld, clr_lockout,
        input  sht_dwn, aud_en, lockout, retry_cnt
    );

    modport slave (
        input  Flt_n, vld, clr_lockout,
        output sht_dwn, aud_en, lockout, retry_cnt
    );
endinterface

// File: rtl/amp_pwr_ctrl.sv
// Power/fault sequencer for the class-D amp: shutdown hold, sample-aligned
// unmute, filtered fault detection with timed retry and lockout.
module amp_pwr_ctrl #(
    parameter int HOLD_CYC       = 250000,
    parameter int RETRY_WAIT_CYC = 2500000,
    parameter int FLT_FILT       = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    amp_pwr_if.slave bus
);

    localparam int CNT_MAX = (HOLD_CYC > RETRY_WAIT_CYC) ? HOLD_CYC : RETRY_WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = '1;
    localparam logic [3:0]       FLT_LIM    = 4'(FLT_FILT);
    localparam logic [1:0]       RETRY_LIM  = 2'(MAX_RETRY);

    typedef enum logic [2:0] {SHUT, WAKE, RUN, FAULT, LOCK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry, retry_nxt, retry_inc;
    logic [3:0]       flt_cnt;
    logic             flt_n_p0, flt_n_p1;
    logic             det_en;
    logic             fault;
    logic             sht_dwn_q, aud_en_q, lockout_q;

    assign det_en = (state == WAKE) || (state == RUN);
    assign fault  = det_en && (flt_cnt >= FLT_LIM);

    // stage p0/p1: two-flop synchronizer for the asynchronous fault pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flt_n_p0 <= 1'b1;
            flt_n_p1 <= 1'b1;
        end else begin
            flt_n_p0 <= bus.Flt_n;
            flt_n_p1 <= flt_n_p0;
        end
    end

    // filter: consecutive synced-low cycles, only counted while the amp is live
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flt_cnt <= 4'd0;
        end else if (det_en && !flt_n_p1) begin
            flt_cnt <= (flt_cnt == 4'hF) ? flt_cnt : flt_cnt + 4'd1;
        end else begin
            flt_cnt <= 4'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        retry_inc = (retry == 2'd3) ? retry : retry + 2'd1;
        cnt_nxt   = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

        case (state)
            SHUT:  if (cnt == HOLD_LAST) state_nxt = WAKE;
            WAKE:  if (bus.vld) state_nxt = RUN;
            RUN: begin
                // clean-run window elapsed: forget earlier faults, park the timer
                if (cnt == RETRY_LAST) begin
                    retry_nxt = 2'd0;
                    cnt_nxt   = cnt;
                end
            end
            FAULT: if (cnt == RETRY_LAST) state_nxt = SHUT;
            LOCK: begin
                if (bus.clr_lockout) begin
                    state_nxt = SHUT;
                    retry_nxt = 2'd0;
                end
            end
            default: state_nxt = SHUT;
        endcase

        // fault only qualifies in WAKE/RUN and overrides vld and the clean-run clear
        if (fault) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_LIM) ? LOCK : FAULT;
        end

        if (state_nxt != state) cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SHUT;
            cnt       <= '0;
            retry     <= 2'd0;
            sht_dwn_q <= 1'b1;
            aud_en_q  <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            sht_dwn_q <= (state_nxt == SHUT) || (state_nxt == FAULT) || (state_nxt == LOCK);
            aud_en_q  <= (state_nxt == RUN);
            lockout_q <= (state_nxt == LOCK);
        end
    end

    assign bus.sht_dwn   = sht_dwn_q;
    assign bus.aud_en    = aud_en_q;
    assign bus.lockout   = lockout_q;
    assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_amp_pwr_ctrl.sv
// Scoreboard bench for amp_pwr_ctrl: scripted scenarios plus random traffic,
// expected outputs from a behavioural model of the sequencing rules.
module tb_amp_pwr_ctrl;

    localparam int HOLD  = 10;
    localparam int RW    = 20;
    localparam int FLT   = 4;
    localparam int MAXR  = 3;

    localparam int M_SHUT  = 0;
    localparam int M_WAKE  = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;
    localparam int M_LOCK  = 4;

    typedef struct {
        bit       sht;
        bit       aud;
        bit       lck;
        bit [1:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    amp_pwr_if bus ();

    amp_pwr_ctrl #(
        .HOLD_CYC       (HOLD),
        .RETRY_WAIT_CYC (RW),
        .FLT_FILT       (FLT),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   mon_cyc = 0;

    // reference model: mode, time spent in mode, low-run of the synced fault pin
    int m_mode = M_SHUT;
    int m_t    = 0;
    int m_low  = 0;
    int m_retry = 0;
    bit m_hist[$];

    task automatic model_step(input bit r, input bit f, input bit v, input bit c);
        exp_t e;
        int   nm;
        bit   live;
        bit   synced;
        if (!r) begin
            m_mode  = M_SHUT;
            m_t     = 0;
            m_low   = 0;
            m_retry = 0;
            m_hist  = '{1'b1, 1'b1};
        end else begin
            live   = (m_mode == M_WAKE) || (m_mode == M_RUN);
            synced = m_hist[1];
            nm     = m_mode;
            if (live && m_low >= FLT) begin
                m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                nm = (m_retry == MAXR) ? M_LOCK : M_FAULT;
            end else begin
                case (m_mode)
                    M_SHUT:  if (m_t + 1 >= HOLD) nm = M_WAKE;
                    M_WAKE:  if (v) nm = M_RUN;
                    M_RUN:   if (m_t + 1 >= RW) m_retry = 0;
                    M_FAULT: if (m_t + 1 >= RW) nm = M_SHUT;
                    default: if (c) begin nm = M_SHUT; m_retry = 0; end
                endcase
            end
            m_low  = (live && !synced) ? m_low + 1 : 0;
            m_t    = (nm != m_mode) ? 0 : m_t + 1;
            m_mode = nm;
            m_hist.push_front(f);
            void'(m_hist.pop_back());
        end
        e.sht = (m_mode == M_SHUT) || (m_mode == M_FAULT) || (m_mode == M_LOCK);
        e.aud = (m_mode == M_RUN);
        e.lck = (m_mode == M_LOCK);
        e.rc  = 2'(m_retry);
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit f, input bit v, input bit c);
        @(negedge clk);
        rst_n           = r;
        bus.Flt_n       = f;
        bus.vld         = v;
        bus.clr_lockout = c;
        model_step(r, f, v, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic flt_low(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // strobe vld every fourth cycle until the model reports RUN
    task automatic go_run();
        int k = 0;
        while (m_mode != M_RUN && k < 200) begin
            step(1'b1, 1'b1, (k % 4) == 3, 1'b0);
            k++;
        end
        tests++;
        if (m_mode != M_RUN) begin
            fails++;
            $display("FAIL go_run: reached mode %0d, required RUN within 200 cycles", m_mode);
        end
    endtask

    task automatic random_phase(input int n);
        int burst = 0;
        bit f;
        for (int i = 0; i < n; i++) begin
            if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 12);
            f = (burst == 0);
            if (burst > 0) burst--;
            step($urandom_range(0, 399) != 0, f,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
    endtask

    // monitor: compare every registered output one step after each stimulus
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                mon_cyc++;
                tests++;
                if (bus.sht_dwn !== e.sht) begin
                    fails++;
                    $display("FAIL sht_dwn cyc %0d: got %b want %b", mon_cyc, bus.sht_dwn, e.sht);
                end
                tests++;
                if (bus.aud_en !== e.aud) begin
                    fails++;
                    $display("FAIL aud_en cyc %0d: got %b want %b", mon_cyc, bus.aud_en, e.aud);
                end
                tests++;
                if (bus.lockout !== e.lck) begin
                    fails++;
                    $display("FAIL lockout cyc %0d: got %b want %b", mon_cyc, bus.lockout, e.lck);
                end
                tests++;
                if (bus.retry_cnt !== e.rc) begin
                    fails++;
                    $display("FAIL retry_cnt cyc %0d: got %0d want %0d", mon_cyc, bus.retry_cnt, e.rc);
                end
            end
        end
    end

    initial begin
        int k;
        rst_n           = 1'b0;
        bus.Flt_n       = 1'b1;
        bus.vld         = 1'b0;
        bus.clr_lockout = 1'b0;

        // reset, then power-up with vld sampled on edge 15
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);

        // short glitch while running
        flt_low(3);
        idle(10);

        // single fault, retry path, re-unmute
        flt_low(10);
        idle(35);
        go_run();

        // clean run clears retry count
        idle(30);

        // three faults in quick succession end in lockout
        for (int n = 0; n < 3; n++) begin
            flt_low(8);
            if (n < 2) begin
                idle(32);
                go_run();
                idle(5);
            end
        end
        idle(10);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);

        // release lockout, then clr in RUN is ignored
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(12);
        go_run();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // fault held through recovery; vld lands on the same cycle the fault declares in WAKE
        k = 0;
        while (m_mode != M_WAKE && k < 200) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            k++;
        end
        k = 0;
        while (m_mode == M_WAKE && k < 20) begin
            step(1'b1, 1'b0, m_low >= FLT, 1'b0);
            k++;
        end
        tests++;
        if (m_mode != M_FAULT) begin
            fails++;
            $display("FAIL wake_fault_setup: model mode %0d, required FAULT", m_mode);
        end

        // reset in the middle of FAULT
        idle(5);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        random_phase(1500);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
